// File: rtl/mem_read_responder.sv
// mem_read_responder: Avalon-MM pipelined read responder backed by a 64-bit word ROM.
// Returns each accepted read after a fixed latency, in order, and throttles the initiator
// with waitrequest during post-reset initialisation and when too many reads are in flight.
module mem_read_responder #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned MAX_PENDING = 4,
  parameter int unsigned INIT_CYCLES = 4,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] address,
  input  logic        read,
  output logic [63:0] readdata,
  output logic        readdatavalid,
  output logic        waitrequest,
  output logic        addr_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = $clog2(MAX_PENDING + 1);
  localparam int unsigned CW = 8;
  localparam int unsigned DW = 64;

  // Contents come from the built-in byte pattern only; an image file cannot be honoured here.
  if (INIT_FILE != "") begin : g_init_file_check
    $error("mem_read_responder: INIT_FILE image loading is not supported, leave it empty");
  end

  typedef enum logic {
    S_INIT,
    S_READY
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   init_cnt_q, init_cnt_d;
  logic [OW-1:0]   pend_q, pend_d;
  logic            wait_q, wait_d;
  logic            err_q, err_d;

  logic            accept_c;
  logic            in_range_c;
  logic [AW-1:0]   idx_c;
  logic [DW-1:0]   rom_word_c;

  logic            v_q       [LATENCY];
  logic [DW-1:0]   d_q       [LATENCY];
  logic            stage_v_c [LATENCY];
  logic [DW-1:0]   stage_d_c [LATENCY];

  assign accept_c      = read & ~wait_q;
  assign in_range_c    = (address[31:AW] == '0);
  assign idx_c         = address[AW-1:0];
  assign waitrequest   = wait_q;
  assign addr_err      = err_q;
  assign readdatavalid = v_q[LATENCY-1];
  assign readdata      = d_q[LATENCY-1];

  // ROM lookup at acceptance: byte lane k of word i is (8*i + k) mod 256, zero when out of range.
  always_comb begin
    rom_word_c = '0;
    if (in_range_c) begin
      for (int k = 0; k < 8; k++) begin
        rom_word_c[8*k +: 8] = 8'({idx_c, 3'(k)});
      end
    end
  end

  // State, init counter, outstanding count, sticky error and waitrequest registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      pend_q     <= '0;
      wait_q     <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      pend_q     <= pend_d;
      wait_q     <= wait_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic; waitrequest is precomputed from the next outstanding count.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    pend_d     = pend_q;
    err_d      = err_q;
    wait_d     = 1'b1;

    case (state_q)
      S_INIT: begin
        if (init_cnt_q == CW'(INIT_CYCLES)) begin
          state_d = S_READY;
        end else begin
          init_cnt_d = init_cnt_q + CW'(1);
        end
      end
      S_READY: begin
        state_d = S_READY;
      end
    endcase

    case ({accept_c, readdatavalid})
      2'b10:   pend_d = pend_q + OW'(1);
      2'b01:   pend_d = pend_q - OW'(1);
      default: pend_d = pend_q;
    endcase

    if (accept_c && !in_range_c) begin
      err_d = 1'b1;
    end

    wait_d = (state_d == S_INIT) || (pend_d == OW'(MAX_PENDING));
  end

  // Stage inputs: stage 0 takes the accepted lookup, later stages shift from the previous one.
  always_comb begin
    for (int i = 0; i < LATENCY; i++) begin
      stage_v_c[i] = 1'b0;
      stage_d_c[i] = '0;
    end
    stage_v_c[0] = accept_c;
    stage_d_c[0] = rom_word_c;
    for (int i = 1; i < LATENCY; i++) begin
      stage_v_c[i] = v_q[i-1];
      stage_d_c[i] = d_q[i-1];
    end
  end

  // Valid/data pipeline; data only moves with valid, so the last stage holds the last response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        v_q[i] <= 1'b0;
        d_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        v_q[i] <= stage_v_c[i];
        if (stage_v_c[i]) begin
          d_q[i] <= stage_d_c[i];
        end
      end
    end
  end

endmodule
